lea_lcd_sequencer: RTL and testbench

- Owns the character LCD bus: drives LCD_DATA/LCD_E/LCD_RS/LCD_RW.
- Runs the HD44780 power-up init sequence.
- Arbitrates two requesters: keypad echo (single char on line 1) and LEA result display (16-byte block on line 2).
- Sits between keypad-entry/LEA core logic and the LCD pins; nothing else touches the LCD bus.

---
 rtl/lea_lcd_pkg.sv | 42 ++++
 rtl/lcd_bus_cycle.sv | 69 ++++++
 rtl/lea_lcd_sequencer.sv | 195 +++++++++++++++++++
 tb/tb_lea_lcd_sequencer.sv | 311 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lea_lcd_pkg.sv
// Shared definitions for the LEA character-LCD sequencer: HD44780 command
// bytes, the sequencer state encoding and small byte-selection helpers.
// Imported by lcd_bus_cycle and lea_lcd_sequencer.
package lea_lcd_pkg;

  // HD44780 command bytes
  localparam logic [7:0] FUNC_SET = 8'h38;  // 8-bit bus, 2 lines, 5x8 font
  localparam logic [7:0] DISP_ON  = 8'h0C;  // display on, cursor off
  localparam logic [7:0] ENTRY    = 8'h06;  // increment address, no shift
  localparam logic [7:0] CLEAR    = 8'h01;  // clear display (slow command)
  localparam logic [7:0] LINE1    = 8'h80;  // DDRAM address of line 1, column 0
  localparam logic [7:0] LINE2    = 8'hC0;  // DDRAM address of line 2, column 0

  typedef enum logic [2:0] {
    PWRUP,
    INIT,
    IDLE,
    KEY_ADDR,
    KEY_CHR,
    RES_ADDR,
    RES_CHR,
    ACK
  } seqState_t;

  // Power-up command list; the last entry is the clear, which needs the long gap.
  function automatic logic [7:0] initCmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return FUNC_SET;
      2'd1:    return DISP_ON;
      2'd2:    return ENTRY;
      default: return CLEAR;
    endcase
  endfunction

  // Byte idx of a 16-char block; byte 0 sits in the top 8 bits.
  function automatic logic [7:0] resByte(input logic [127:0] blk, input logic [3:0] idx);
    logic [127:0] sh;
    sh = blk << {idx, 3'b000};
    return sh[127:120];
  endfunction

endpackage

// File: rtl/lcd_bus_cycle.sv
// One HD44780 write cycle: registers RS/DATA, then strobes E and waits out the gap.
// Latency: start -> done is T_SETUP+T_PW+T_GAP cycles (+T_CLR when long); done on the last gap cycle.
// Backpressure: none; start is only legal when idle or in the done cycle (start wins and restarts).
// Ports: clk/rstN clock and async active-low reset; start/rs/data/long request a cycle;
//        done pulses at the end; LCD_E/LCD_RS/LCD_DATA drive the panel pins (all registered).
module lcd_bus_cycle
  import lea_lcd_pkg::*;
#(
  parameter int T_SETUP = 1,  // must be >= 1: E is low in the cycle RS/DATA are registered
  parameter int T_PW    = 2,
  parameter int T_GAP   = 4,
  parameter int T_CLR   = 16
) (
  input  logic       clk,
  input  logic       rstN,
  input  logic       start,
  input  logic       rs,
  input  logic [7:0] data,
  input  logic       long,
  output logic       done,
  output logic       LCD_E,
  output logic       LCD_RS,
  output logic [7:0] LCD_DATA
);

  localparam int SHORT_LEN = T_SETUP + T_PW + T_GAP;
  localparam int LONG_LEN  = SHORT_LEN + T_CLR;
  localparam int CW        = $clog2(LONG_LEN + 1);

  localparam logic [CW-1:0] SHORT_LAST = CW'(SHORT_LEN - 1);
  localparam logic [CW-1:0] LONG_LAST  = CW'(LONG_LEN - 1);
  localparam logic [CW-1:0] E_ON       = CW'(T_SETUP);
  localparam logic [CW-1:0] E_OFF      = CW'(T_SETUP + T_PW);

  logic          active;
  logic [CW-1:0] cnt;
  logic [CW-1:0] lastCnt;
  logic [CW-1:0] nextCnt;

  assign nextCnt = cnt + CW'(1);
  assign done    = active && (cnt == lastCnt);

  // E is registered from the next count value so the pin never glitches.
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      active   <= 1'b0;
      cnt      <= '0;
      lastCnt  <= '0;
      LCD_E    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_DATA <= 8'h00;
    end else if (start) begin
      active   <= 1'b1;
      cnt      <= '0;
      lastCnt  <= long ? LONG_LAST : SHORT_LAST;
      LCD_RS   <= rs;
      LCD_DATA <= data;
      LCD_E    <= 1'b0;
    end else if (active) begin
      cnt   <= nextCnt;
      LCD_E <= (nextCnt >= E_ON) && (nextCnt < E_OFF);
      if (done) begin
        active <= 1'b0;
        LCD_E  <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/lea_lcd_sequencer.sv
// Owns the character LCD: HD44780 power-up init, then serves keypad echo (line 1) and result blocks (line 2).
// Latency: acceptance -> ACK is 2L+1 cycles for a key echo, 17L+1 for a result block (L = one bus cycle).
// Backpressure: requests are levels held off while BUSY; key wins ties; a burst is never preempted.
// Ports: CLK/RST clock and async active-low reset; KEY_REQ/KEY_POS/KEY_CHAR -> KEY_ACK;
//        RES_REQ/RES_DATA -> RES_ACK; INIT_DONE, BUSY status; LCD_DATA/LCD_E/LCD_RS/LCD_RW panel pins.
module lea_lcd_sequencer
  import lea_lcd_pkg::*;
#(
  parameter int T_PWRUP = 8,
  parameter int T_SETUP = 1,
  parameter int T_PW    = 2,
  parameter int T_GAP   = 4,
  parameter int T_CLR   = 16
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         KEY_REQ,
  input  logic [3:0]   KEY_POS,
  input  logic [7:0]   KEY_CHAR,
  output logic         KEY_ACK,
  input  logic         RES_REQ,
  input  logic [127:0] RES_DATA,
  output logic         RES_ACK,
  output logic         INIT_DONE,
  output logic         BUSY,
  output logic [7:0]   LCD_DATA,
  output logic         LCD_E,
  output logic         LCD_RS,
  output logic         LCD_RW
);

  localparam int PW_W = $clog2(T_PWRUP + 1);
  localparam logic [PW_W-1:0] PWR_LAST = PW_W'(T_PWRUP - 1);

  seqState_t       state;
  seqState_t       nextState;
  logic [PW_W-1:0] pwrCnt;
  logic [1:0]      initIdx;
  logic [3:0]      resIdx;
  logic [7:0]      keyChr;
  logic [127:0]    resBlk;
  logic            ackIsKey;
  logic            initDone;

  logic            busStart;
  logic            busRs;
  logic [7:0]      busData;
  logic            busLong;
  logic            busDone;
  logic            latchKey;
  logic            latchRes;
  logic            initStep;
  logic            resStep;
  logic            setInitDone;

  lcd_bus_cycle #(
    .T_SETUP (T_SETUP),
    .T_PW    (T_PW),
    .T_GAP   (T_GAP),
    .T_CLR   (T_CLR)
  ) uBus (
    .clk      (CLK),
    .rstN     (RST),
    .start    (busStart),
    .rs       (busRs),
    .data     (busData),
    .long     (busLong),
    .done     (busDone),
    .LCD_E    (LCD_E),
    .LCD_RS   (LCD_RS),
    .LCD_DATA (LCD_DATA)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) state <= PWRUP;
    else      state <= nextState;
  end

  // The next bus cycle is launched in the same cycle the previous one reports
  // done, so consecutive writes run back to back with no dead cycle.
  always_comb begin
    nextState   = state;
    busStart    = 1'b0;
    busRs       = 1'b0;
    busData     = 8'h00;
    busLong     = 1'b0;
    latchKey    = 1'b0;
    latchRes    = 1'b0;
    initStep    = 1'b0;
    resStep     = 1'b0;
    setInitDone = 1'b0;
    case (state)
      PWRUP: begin
        if (pwrCnt == PWR_LAST) begin
          busStart  = 1'b1;
          busData   = initCmd(2'd0);
          nextState = INIT;
        end
      end
      INIT: begin
        if (busDone) begin
          if (initIdx == 2'd3) begin
            setInitDone = 1'b1;
            nextState   = IDLE;
          end else begin
            busStart = 1'b1;
            busData  = initCmd(initIdx + 2'd1);
            busLong  = (initIdx == 2'd2);
            initStep = 1'b1;
          end
        end
      end
      IDLE: begin
        // The address command uses the live inputs; they are latched on this same edge.
        if (KEY_REQ) begin
          latchKey  = 1'b1;
          busStart  = 1'b1;
          busData   = LINE1 | {4'h0, KEY_POS};
          nextState = KEY_ADDR;
        end else if (RES_REQ) begin
          latchRes  = 1'b1;
          busStart  = 1'b1;
          busData   = LINE2;
          nextState = RES_ADDR;
        end
      end
      KEY_ADDR: begin
        if (busDone) begin
          busStart  = 1'b1;
          busRs     = 1'b1;
          busData   = keyChr;
          nextState = KEY_CHR;
        end
      end
      KEY_CHR: begin
        if (busDone) nextState = ACK;
      end
      RES_ADDR: begin
        if (busDone) begin
          busStart  = 1'b1;
          busRs     = 1'b1;
          busData   = resByte(resBlk, 4'd0);
          nextState = RES_CHR;
        end
      end
      RES_CHR: begin
        if (busDone) begin
          if (resIdx == 4'd15) begin
            nextState = ACK;
          end else begin
            busStart = 1'b1;
            busRs    = 1'b1;
            busData  = resByte(resBlk, resIdx + 4'd1);
            resStep  = 1'b1;
          end
        end
      end
      ACK:     nextState = IDLE;
      default: nextState = PWRUP;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      pwrCnt   <= '0;
      initIdx  <= 2'd0;
      resIdx   <= 4'd0;
      keyChr   <= 8'h00;
      resBlk   <= '0;
      ackIsKey <= 1'b0;
      initDone <= 1'b0;
    end else begin
      if (state == PWRUP && pwrCnt != PWR_LAST) pwrCnt <= pwrCnt + PW_W'(1);
      if (initStep)    initIdx  <= initIdx + 2'd1;
      if (setInitDone) initDone <= 1'b1;
      if (latchKey) begin
        keyChr   <= KEY_CHAR;
        ackIsKey <= 1'b1;
      end
      if (latchRes) begin
        resBlk   <= RES_DATA;
        resIdx   <= 4'd0;
        ackIsKey <= 1'b0;
      end
      if (resStep) resIdx <= resIdx + 4'd1;
    end
  end

  assign KEY_ACK   = (state == ACK) && ackIsKey;
  assign RES_ACK   = (state == ACK) && !ackIsKey;
  assign BUSY      = (state != IDLE);
  assign INIT_DONE = initDone;
  assign LCD_RW    = 1'b0;

endmodule

// File: tb/tb_lea_lcd_sequencer.sv
// Bench for lea_lcd_sequencer: randomized key/result traffic against a
// write-list and latency model derived from the bus timing parameters.
`timescale 1ns/1ps
module tb_lea_lcd_sequencer;

  localparam int T_PWRUP  = 8;
  localparam int T_SETUP  = 1;
  localparam int T_PW     = 2;
  localparam int T_GAP    = 4;
  localparam int T_CLR    = 16;
  localparam int L        = T_SETUP + T_PW + T_GAP;
  localparam int L_LONG   = L + T_CLR;
  localparam int INIT_LAT = T_PWRUP + 3 * L + L_LONG;
  localparam int KEY_LAT  = 2 * L + 1;
  localparam int RES_LAT  = 17 * L + 1;

  logic         CLK = 1'b0;
  logic         RST = 1'b1;
  logic         KEY_REQ = 1'b0;
  logic [3:0]   KEY_POS = 4'h0;
  logic [7:0]   KEY_CHAR = 8'h00;
  logic         KEY_ACK;
  logic         RES_REQ = 1'b0;
  logic [127:0] RES_DATA = '0;
  logic         RES_ACK;
  logic         INIT_DONE;
  logic         BUSY;
  logic [7:0]   LCD_DATA;
  logic         LCD_E;
  logic         LCD_RS;
  logic         LCD_RW;

  always #5 CLK = ~CLK;

  lea_lcd_sequencer dut (
    .CLK       (CLK),
    .RST       (RST),
    .KEY_REQ   (KEY_REQ),
    .KEY_POS   (KEY_POS),
    .KEY_CHAR  (KEY_CHAR),
    .KEY_ACK   (KEY_ACK),
    .RES_REQ   (RES_REQ),
    .RES_DATA  (RES_DATA),
    .RES_ACK   (RES_ACK),
    .INIT_DONE (INIT_DONE),
    .BUSY      (BUSY),
    .LCD_DATA  (LCD_DATA),
    .LCD_E     (LCD_E),
    .LCD_RS    (LCD_RS),
    .LCD_RW    (LCD_RW)
  );

  int nChecks = 0;
  int nErrors = 0;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    nChecks++;
    if (obs !== exp) begin
      nErrors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Write-list model: every panel write is {rs, data}, in bus order.
  logic [8:0] gotQ[$];
  logic [8:0] expQ[$];
  logic       prevE = 1'b0;
  int         eHigh = 0;
  bit         rwBad = 1'b0;

  always @(negedge CLK) begin
    if (LCD_RW !== 1'b0) rwBad = 1'b1;
    if (!RST) begin
      prevE = 1'b0;
      eHigh = 0;
    end else begin
      if (LCD_E) begin
        eHigh++;
      end else if (prevE) begin
        gotQ.push_back({LCD_RS, LCD_DATA});
        check("e_width", eHigh, T_PW);
        eHigh = 0;
      end
      prevE = LCD_E;
    end
  end

  task automatic pushInit();
    expQ.push_back({1'b0, 8'h38});
    expQ.push_back({1'b0, 8'h0C});
    expQ.push_back({1'b0, 8'h06});
    expQ.push_back({1'b0, 8'h01});
  endtask

  task automatic pushKey(input logic [3:0] pos, input logic [7:0] ch);
    expQ.push_back({1'b0, 8'h80 + {4'h0, pos}});
    expQ.push_back({1'b1, ch});
  endtask

  task automatic pushRes(input logic [127:0] blk);
    expQ.push_back({1'b0, 8'hC0});
    for (int i = 0; i < 16; i++) expQ.push_back({1'b1, blk[127-8*i -: 8]});
  endtask

  task automatic compareWrites(input string tag);
    check({tag, "_count"}, gotQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++)
      check(tag, (i < gotQ.size()) ? gotQ[i] : 9'h1FF, expQ[i]);
    gotQ.delete();
    expQ.delete();
  endtask

  function automatic logic [127:0] randBlk();
    logic [127:0] b;
    b = '0;
    for (int i = 0; i < 16; i++) b = {b[119:0], 8'($urandom_range(32, 126))};
    return b;
  endfunction

  // Single requester; optionally drops REQ right after acceptance. Inputs are
  // scrambled after acceptance, so the writes only match if they were latched.
  task automatic runOne(input bit isKey, input logic [3:0] pos, input logic [7:0] ch,
                        input logic [127:0] blk, input bit drop);
    int n, lat;
    bit seen, busyLow, wrongAck;
    string tag;
    lat = isKey ? KEY_LAT : RES_LAT;
    tag = isKey ? "key" : "res";
    n = 0; seen = 0; busyLow = 0; wrongAck = 0;
    if (isKey) begin
      KEY_POS = pos; KEY_CHAR = ch; KEY_REQ = 1'b1;
      pushKey(pos, ch);
    end else begin
      RES_DATA = blk; RES_REQ = 1'b1;
      pushRes(blk);
    end
    while (!seen && n < lat + 20) begin
      @(negedge CLK);
      n++;
      if (n == 1) begin
        KEY_POS  = 4'($urandom);
        KEY_CHAR = 8'($urandom);
        RES_DATA = {$urandom, $urandom, $urandom, $urandom};
        if (drop) begin KEY_REQ = 1'b0; RES_REQ = 1'b0; end
      end
      if (!BUSY) busyLow = 1'b1;
      if (isKey ? RES_ACK : KEY_ACK) wrongAck = 1'b1;
      if (isKey ? KEY_ACK : RES_ACK) seen = 1'b1;
    end
    KEY_REQ = 1'b0;
    RES_REQ = 1'b0;
    check({tag, "_ack_lat"}, n, lat);
    check({tag, "_busy_held"}, busyLow, 1'b0);
    check({tag, "_wrong_ack"}, wrongAck, 1'b0);
    @(negedge CLK);
    check({tag, "_ack_one_cycle"}, KEY_ACK | RES_ACK, 1'b0);
    check({tag, "_back_idle"}, BUSY, 1'b0);
    compareWrites({tag, "_wr"});
  endtask

  // Both requests in the same IDLE cycle: key first, result right after.
  task automatic runBoth(input logic [3:0] pos, input logic [7:0] ch, input logic [127:0] blk);
    int n;
    KEY_POS = pos; KEY_CHAR = ch; RES_DATA = blk;
    KEY_REQ = 1'b1; RES_REQ = 1'b1;
    pushKey(pos, ch);
    pushRes(blk);
    n = 0;
    while (!KEY_ACK && !RES_ACK && n < KEY_LAT + 20) begin
      @(negedge CLK);
      n++;
    end
    check("both_key_first", KEY_ACK, 1'b1);
    check("both_key_lat", n, KEY_LAT);
    KEY_REQ = 1'b0;
    n = 0;
    while (!RES_ACK && n < RES_LAT + 20) begin
      @(negedge CLK);
      n++;
    end
    RES_REQ = 1'b0;
    check("both_res_lat", n, RES_LAT + 1);
    @(negedge CLK);
    check("both_back_idle", BUSY, 1'b0);
    compareWrites("both_wr");
  endtask

  // Key raised while the 5th result char is on the bus: no preemption.
  task automatic runResThenKey(input logic [127:0] blk, input logic [3:0] pos,
                               input logic [7:0] ch, input int off);
    int n, resN, keyN;
    RES_DATA = blk; RES_REQ = 1'b1;
    pushRes(blk);
    pushKey(pos, ch);
    n = 0; resN = 0; keyN = 0;
    while (keyN == 0 && n < RES_LAT + KEY_LAT + 40) begin
      @(negedge CLK);
      n++;
      if (n == 1) RES_REQ = 1'b0;
      if (n == 5 * L + 1 + off) begin
        KEY_POS = pos; KEY_CHAR = ch; KEY_REQ = 1'b1;
      end
      if (RES_ACK && resN == 0) resN = n;
      if (KEY_ACK) keyN = n;
    end
    KEY_REQ = 1'b0;
    check("nopre_res_lat", resN, RES_LAT);
    check("nopre_key_lat", keyN, RES_LAT + 1 + KEY_LAT);
    @(negedge CLK);
    check("nopre_back_idle", BUSY, 1'b0);
    compareWrites("nopre_wr");
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, initN, keyN;
    bit resAckSeen;
    logic [127:0] blk;

    #1 RST = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_busy", BUSY, 1'b1);
    check("rst_e", LCD_E, 1'b0);
    check("rst_rs", LCD_RS, 1'b0);
    check("rst_rw", LCD_RW, 1'b0);
    check("rst_data", LCD_DATA, 8'h00);
    check("rst_init_done", INIT_DONE, 1'b0);
    check("rst_key_ack", KEY_ACK, 1'b0);
    check("rst_res_ack", RES_ACK, 1'b0);

    // Power-up init
    pushInit();
    RST = 1'b1;
    n = 0;
    while (!INIT_DONE && n < INIT_LAT + 20) begin
      @(negedge CLK);
      n++;
    end
    check("init_lat", n, INIT_LAT);
    check("init_idle", BUSY, 1'b0);
    compareWrites("init_wr");

    // Directed: key echo and the ASCII result block
    runOne(1'b1, 4'd3, 8'h41, '0, 1'b0);
    blk = "0123456789ABCDEF";
    runOne(1'b0, 4'd0, 8'h00, blk, 1'b0);
    runBoth(4'd15, 8'h7A, randBlk());
    runResThenKey(randBlk(), 4'd9, 8'h23, 0);

    // Randomized mix
    for (int it = 0; it < 12; it++) begin
      case ($urandom_range(0, 3))
        0:       runOne(1'b1, 4'($urandom), 8'($urandom), '0, 1'($urandom));
        1:       runOne(1'b0, 4'd0, 8'h00, randBlk(), 1'($urandom));
        2:       runBoth(4'($urandom), 8'($urandom), randBlk());
        default: runResThenKey(randBlk(), 4'($urandom), 8'($urandom), int'($urandom_range(0, L - 1)));
      endcase
    end

    // Reset while E is high mid-burst; a key request is held through re-init.
    RES_DATA = randBlk();
    RES_REQ = 1'b1;
    n = 0;
    while (n < 60 && !(n >= 40 && LCD_E)) begin
      @(negedge CLK);
      n++;
    end
    check("abort_e_was_high", LCD_E, 1'b1);
    RES_REQ = 1'b0;
    RST = 1'b0;
    #1;
    check("abort_e_low", LCD_E, 1'b0);
    check("abort_init_done", INIT_DONE, 1'b0);
    check("abort_busy", BUSY, 1'b1);
    resAckSeen = 1'b0;
    repeat (4) begin
      @(negedge CLK);
      if (RES_ACK) resAckSeen = 1'b1;
    end
    gotQ.delete();
    expQ.delete();
    KEY_POS = 4'd7; KEY_CHAR = 8'h5A; KEY_REQ = 1'b1;
    pushInit();
    pushKey(4'd7, 8'h5A);
    RST = 1'b1;
    n = 0; initN = 0; keyN = 0;
    while (keyN == 0 && n < INIT_LAT + KEY_LAT + 40) begin
      @(negedge CLK);
      n++;
      if (INIT_DONE && initN == 0) initN = n;
      if (RES_ACK) resAckSeen = 1'b1;
      if (KEY_ACK) keyN = n;
    end
    KEY_REQ = 1'b0;
    check("reinit_lat", initN, INIT_LAT);
    check("reinit_held_key_lat", keyN, INIT_LAT + KEY_LAT);
    check("abort_no_res_ack", resAckSeen, 1'b0);
    @(negedge CLK);
    compareWrites("reinit_wr");

    check("lcd_rw_low", rwBad, 1'b0);
    $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
    $finish;
  end

endmodule
